ptw_mem_arbiter: RTL and testbench

- Shares the single page-table-walk memory port (AXI master read path) between the instruction-side TLB and the data-side TLB.
- Each TLB issues single-cycle walk-read pulses. The block captures each pulse, arbitrates round-robin and drives one outstanding read at a time to the AXI master with a valid/ready handshake.
- The returned PTE is routed back only to the requester that owns the read.
- Sits between both TLBs' walker ports and the AXI master.

---
 rtl/ptw_mem_arbiter_pkg.sv | 27 ++
 rtl/ptw_mem_arbiter_if.sv | 59 +++++
 rtl/ptw_mem_arbiter_req_capture.sv | 62 ++++++
 rtl/ptw_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ptw_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ptw_arb_pkg
// Description : Shared constants for the page-table-walk memory arbiter:
//               FSM state encoding and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package ptw_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t ISSUE     = 2'd1;
  localparam state_t WAIT_RESP = 2'd2;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Round-robin choice among requesters that still want service.
  // With both eligible the pointer decides, otherwise the single one wins.
  function automatic logic rr_pick(input logic want_i, input logic want_d,
                                   input logic rr_ptr);
    return (want_i && want_d) ? rr_ptr : want_d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : ptw_mem_arbiter_if
// Description : Bundles both TLB walker ports, the AXI read-master port and
//               the arbiter status outputs.
//               slave  : arbiter view (takes requests/read data, drives
//                        address, PTE returns and status)
//               master : environment view (TLBs and AXI master)
// Revision    : 1.0 - initial release
// ============================================================================
interface ptw_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  // ITLB walker port
  logic                  I_ADDR_VALID;
  logic [ADDR_WIDTH-1:0] I_ADDR;
  logic                  I_KILL;
  logic                  I_DATA_VALID;
  logic [DATA_WIDTH-1:0] I_DATA;
  // DTLB walker port
  logic                  D_ADDR_VALID;
  logic [ADDR_WIDTH-1:0] D_ADDR;
  logic                  D_KILL;
  logic                  D_DATA_VALID;
  logic [DATA_WIDTH-1:0] D_DATA;
  // AXI read master port
  logic                  M_ADDR_VALID;
  logic [ADDR_WIDTH-1:0] M_ADDR;
  logic                  M_ADDR_READY;
  logic                  M_DATA_VALID;
  logic [DATA_WIDTH-1:0] M_DATA;
  // Status
  logic                  BUSY;
  logic                  OWNER;
  logic [1:0]            OVERFLOW;

  modport slave (
    input  I_ADDR_VALID, I_ADDR, I_KILL,
    output I_DATA_VALID, I_DATA,
    input  D_ADDR_VALID, D_ADDR, D_KILL,
    output D_DATA_VALID, D_DATA,
    output M_ADDR_VALID, M_ADDR,
    input  M_ADDR_READY, M_DATA_VALID, M_DATA,
    output BUSY, OWNER, OVERFLOW
  );

  modport master (
    output I_ADDR_VALID, I_ADDR, I_KILL,
    input  I_DATA_VALID, I_DATA,
    output D_ADDR_VALID, D_ADDR, D_KILL,
    input  D_DATA_VALID, D_DATA,
    input  M_ADDR_VALID, M_ADDR,
    output M_ADDR_READY, M_DATA_VALID, M_DATA,
    input  BUSY, OWNER, OVERFLOW
  );

endinterface
`default_nettype wire

// File: rtl/ptw_mem_arbiter_req_capture.sv
`default_nettype none
// ============================================================================
// Module      : ptw_req_capture
// Description : Per-requester walk-read capture: pending flag, address
//               register and sticky overflow flag. Kill beats a same-cycle
//               request; a request arriving while one is already pending is
//               dropped (address kept) and flagged as overflow.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_addr_valid    - request pulse
//               i_addr          - request address
//               i_kill          - abandon this requester's request
//               i_clear         - request granted by the arbiter
//               o_pending       - request waiting for grant
//               o_addr          - captured address
//               o_overflow      - sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_req_capture #(
  parameter int ADDR_WIDTH = 64
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_addr_valid,
  input  wire logic [ADDR_WIDTH-1:0] i_addr,
  input  wire logic                  i_kill,
  input  wire logic                  i_clear,
  output logic                       o_pending,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_overflow
);

  logic                  r_pending;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_kill) begin
        r_pending <= 1'b0;
      end else if (i_addr_valid && !r_pending) begin
        r_pending <= 1'b1;
        r_addr    <= i_addr;
      end else if (i_clear) begin
        r_pending <= 1'b0;
      end
      // A pulse landing on an already-pending request is lost; remember it.
      if (i_addr_valid && r_pending && !i_kill) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_addr     = r_addr;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ptw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ptw_mem_arbiter
// Description : Shares one page-table-walk AXI read port between ITLB and
//               DTLB. Captures request pulses, grants round-robin, keeps a
//               single read outstanding and routes the returned PTE only to
//               the owning requester. A kill on the owner mid-flight lets
//               the AXI transfer finish but suppresses the PTE return.
// Ports       : CLK, RSTN - clock, async active-low reset
//               bus       - ptw_mem_arbiter_if.slave (both TLB walker ports,
//                           AXI read master, BUSY/OWNER/OVERFLOW status)
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_mem_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  wire logic       CLK,
  input  wire logic       RSTN,
  ptw_mem_arbiter_if.slave bus
);

  logic [1:0]            w_pend;
  logic [1:0]            w_kill;
  logic [1:0]            w_elig;
  logic [1:0]            w_clear;
  logic [1:0]            w_ovf;
  logic [ADDR_WIDTH-1:0] w_addr_i;
  logic [ADDR_WIDTH-1:0] w_addr_d;
  logic                  w_do_gnt;
  logic                  w_gnt;
  logic                  w_owner_kill;

  state_t                r_state;
  logic                  r_rr;
  logic                  r_owner;
  logic [1:0]            r_discard;
  logic                  r_m_valid;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic                  r_i_dv;
  logic                  r_d_dv;
  logic [DATA_WIDTH-1:0] r_i_data;
  logic [DATA_WIDTH-1:0] r_d_data;

  ptw_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_cap_i (
    .clk          (CLK),
    .rst_n        (RSTN),
    .i_addr_valid (bus.I_ADDR_VALID),
    .i_addr       (bus.I_ADDR),
    .i_kill       (bus.I_KILL),
    .i_clear      (w_clear[REQ_I]),
    .o_pending    (w_pend[REQ_I]),
    .o_addr       (w_addr_i),
    .o_overflow   (w_ovf[REQ_I])
  );

  ptw_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_cap_d (
    .clk          (CLK),
    .rst_n        (RSTN),
    .i_addr_valid (bus.D_ADDR_VALID),
    .i_addr       (bus.D_ADDR),
    .i_kill       (bus.D_KILL),
    .i_clear      (w_clear[REQ_D]),
    .o_pending    (w_pend[REQ_D]),
    .o_addr       (w_addr_d),
    .o_overflow   (w_ovf[REQ_D])
  );

  always_comb begin
    w_kill       = {bus.D_KILL, bus.I_KILL};
    // A request being killed this cycle must not be granted.
    w_elig       = w_pend & ~w_kill;
    w_gnt        = rr_pick(w_elig[REQ_I], w_elig[REQ_D], r_rr);
    w_do_gnt     = (r_state == IDLE) && (|w_elig);
    w_clear      = 2'b00;
    if (w_do_gnt) begin
      w_clear[w_gnt] = 1'b1;
    end
    w_owner_kill = w_kill[r_owner];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_rr      <= REQ_I;
      r_owner   <= REQ_I;
      r_discard <= 2'b00;
      r_m_valid <= 1'b0;
      r_m_addr  <= '0;
      r_i_dv    <= 1'b0;
      r_d_dv    <= 1'b0;
      r_i_data  <= '0;
      r_d_data  <= '0;
    end else begin
      r_i_dv <= 1'b0;
      r_d_dv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_do_gnt) begin
            r_owner   <= w_gnt;
            r_m_addr  <= (w_gnt == REQ_D) ? w_addr_d : w_addr_i;
            r_m_valid <= 1'b1;
            r_rr      <= ~w_gnt;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // AXI valid cannot be withdrawn, so a kill only marks the read.
          if (w_owner_kill) begin
            r_discard[r_owner] <= 1'b1;
          end
          if (bus.M_ADDR_READY) begin
            r_m_valid <= 1'b0;
            r_state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (bus.M_DATA_VALID) begin
            // A kill in the return cycle also suppresses the PTE.
            if (!(r_discard[r_owner] || w_owner_kill)) begin
              if (r_owner == REQ_D) begin
                r_d_data <= bus.M_DATA;
                r_d_dv   <= 1'b1;
              end else begin
                r_i_data <= bus.M_DATA;
                r_i_dv   <= 1'b1;
              end
            end
            r_discard[r_owner] <= 1'b0;
            r_state            <= IDLE;
          end else if (w_owner_kill) begin
            r_discard[r_owner] <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.M_ADDR_VALID = r_m_valid;
  assign bus.M_ADDR       = r_m_addr;
  assign bus.I_DATA_VALID = r_i_dv;
  assign bus.I_DATA       = r_i_data;
  assign bus.D_DATA_VALID = r_d_dv;
  assign bus.D_DATA       = r_d_data;
  assign bus.BUSY         = (r_state != IDLE);
  assign bus.OWNER        = r_owner;
  assign bus.OVERFLOW     = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ptw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptw_mem_arbiter
// Description : Self-checking bench for ptw_mem_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptw_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;

  ptw_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ptw_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- model
  // m_ph: 0 = no read in flight, 1 = address offered, 2 = awaiting data
  bit          m_pend [2];
  logic [63:0] m_paddr[2];
  int          m_ph   = 0;
  bit          m_own  = 1'b0;
  bit          m_rr   = 1'b0;
  bit          m_drop = 1'b0;
  logic [63:0] m_addr = '0;
  bit          m_mv   = 1'b0;
  bit          m_dv   [2];
  logic [63:0] m_data [2];
  logic [1:0]  m_ovf  = 2'b00;

  task automatic model_step();
    bit          pulse[2];
    bit          kill [2];
    bit          old  [2];
    bit          gnt  [2];
    logic [63:0] a    [2];
    bit          w0, w1;
    int          g;
    if (!RSTN) begin
      for (int r = 0; r < 2; r++) begin
        m_pend[r] = 0; m_paddr[r] = '0; m_dv[r] = 0; m_data[r] = '0;
      end
      m_ph = 0; m_own = 0; m_rr = 0; m_drop = 0; m_addr = '0; m_mv = 0;
      m_ovf = 2'b00;
      return;
    end
    pulse[0] = bus.I_ADDR_VALID; pulse[1] = bus.D_ADDR_VALID;
    kill[0]  = bus.I_KILL;       kill[1]  = bus.D_KILL;
    a[0]     = bus.I_ADDR;       a[1]     = bus.D_ADDR;
    for (int r = 0; r < 2; r++) begin
      old[r] = m_pend[r]; gnt[r] = 0; m_dv[r] = 0;
    end
    if (m_ph == 0) begin
      w0 = old[0] && !kill[0];
      w1 = old[1] && !kill[1];
      if (w0 || w1) begin
        g = (w0 && w1) ? int'(m_rr) : (w1 ? 1 : 0);
        gnt[g] = 1;
        m_own  = g[0];
        m_addr = m_paddr[g];
        m_mv   = 1;
        m_rr   = (g == 0);
        m_drop = 0;
        m_ph   = 1;
      end
    end else if (m_ph == 1) begin
      if (kill[m_own]) m_drop = 1;
      if (bus.M_ADDR_READY) begin
        m_mv = 0;
        m_ph = 2;
      end
    end else begin
      if (bus.M_DATA_VALID) begin
        if (!m_drop && !kill[m_own]) begin
          m_data[m_own] = bus.M_DATA;
          m_dv[m_own]   = 1;
        end
        m_drop = 0;
        m_ph   = 0;
      end else if (kill[m_own]) begin
        m_drop = 1;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (kill[r]) m_pend[r] = 0;
      else if (pulse[r] && !old[r]) begin
        m_pend[r]  = 1;
        m_paddr[r] = a[r];
      end else if (gnt[r]) m_pend[r] = 0;
      if (pulse[r] && old[r] && !kill[r]) m_ovf[r] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RSTN);
    model_step();
  end

  // ------------------------------------------------------------- checking
  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    chk("m_addr_valid", 64'(bus.M_ADDR_VALID), 64'(m_mv));
    chk("m_addr",       bus.M_ADDR,            m_addr);
    chk("busy",         64'(bus.BUSY),         64'(m_ph != 0));
    chk("owner",        64'(bus.OWNER),        64'(m_own));
    chk("overflow",     64'(bus.OVERFLOW),     64'(m_ovf));
    chk("i_data_valid", 64'(bus.I_DATA_VALID), 64'(m_dv[0]));
    chk("i_data",       bus.I_DATA,            m_data[0]);
    chk("d_data_valid", 64'(bus.D_DATA_VALID), 64'(m_dv[1]));
    chk("d_data",       bus.D_DATA,            m_data[1]);
  end

  initial forever begin
    @(posedge CLK);
    if (RSTN && bus.M_ADDR_VALID && bus.M_ADDR_READY) hs_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.I_ADDR_VALID = 1'b0;
    bus.I_KILL       = 1'b0;
    bus.D_ADDR_VALID = 1'b0;
    bus.D_KILL       = 1'b0;
    bus.M_DATA_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    clr();
    step();
    step();
    RSTN = 1'b1;
    step();
  endtask

  task automatic wait_mv(input string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.M_ADDR_VALID) seen = 1;
      else step();
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout, got no read address expected one", nm);
    end
  endtask

  // Wait for the read, check its address, return data; leaves the bench in
  // the cycle where the PTE return is visible.
  task automatic serve(input string nm, input logic [63:0] exp_addr,
                       input logic [63:0] data);
    wait_mv(nm);
    chk(nm, bus.M_ADDR, exp_addr);
    step();
    step();
    bus.M_DATA_VALID = 1'b1;
    bus.M_DATA       = data;
    step();
    clr();
  endtask

  task automatic pulse_pair(input logic [63:0] ai, input logic [63:0] ad);
    bus.I_ADDR_VALID = 1'b1; bus.I_ADDR = ai;
    bus.D_ADDR_VALID = 1'b1; bus.D_ADDR = ad;
    step();
    clr();
  endtask

  int hs0;

  initial begin
    clr();
    bus.I_ADDR = '0; bus.D_ADDR = '0; bus.M_DATA = '0;
    bus.M_ADDR_READY = 1'b1;

    // Reset state and single ITLB request
    do_reset();
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_m_addr", bus.M_ADDR, 64'd0);
    bus.I_ADDR_VALID = 1'b1; bus.I_ADDR = 64'h8000_1000;     // cycle 0
    step(); clr();                                            // cycle 1
    chk("t1_c1_valid", 64'(bus.M_ADDR_VALID), 64'd0);
    step();                                                   // cycle 2
    chk("t1_c2_valid", 64'(bus.M_ADDR_VALID), 64'd1);
    chk("t1_c2_addr", bus.M_ADDR, 64'h8000_1000);
    step();                                                   // cycle 3
    chk("t1_c3_valid", 64'(bus.M_ADDR_VALID), 64'd0);
    chk("t1_c3_busy", 64'(bus.BUSY), 64'd1);
    step();                                                   // cycle 4
    step();                                                   // cycle 5
    bus.M_DATA_VALID = 1'b1; bus.M_DATA = 64'h0000_0000_2000_00CF;
    step(); clr();                                            // cycle 6
    chk("t1_c6_i_dv", 64'(bus.I_DATA_VALID), 64'd1);
    chk("t1_c6_i_data", bus.I_DATA, 64'h2000_00CF);
    chk("t1_c6_d_dv", 64'(bus.D_DATA_VALID), 64'd0);
    step();                                                   // cycle 7
    chk("t1_c7_i_dv", 64'(bus.I_DATA_VALID), 64'd0);
    chk("t1_c7_i_hold", bus.I_DATA, 64'h2000_00CF);
    chk("t1_c7_busy", 64'(bus.BUSY), 64'd0);

    // Round-robin
    do_reset();
    pulse_pair(64'h100, 64'h200);
    serve("rr1_first", 64'h100, 64'hA1);
    chk("rr1_first_i_dv", 64'(bus.I_DATA_VALID), 64'd1);
    serve("rr1_second", 64'h200, 64'hB2);
    chk("rr1_second_d_dv", 64'(bus.D_DATA_VALID), 64'd1);
    chk("rr1_second_d_data", bus.D_DATA, 64'hB2);
    chk("rr1_second_owner", 64'(bus.OWNER), 64'd1);
    pulse_pair(64'h110, 64'h210);
    serve("rr2_first", 64'h110, 64'hA3);
    serve("rr2_second", 64'h210, 64'hB4);
    bus.I_ADDR_VALID = 1'b1; bus.I_ADDR = 64'h120;
    step(); clr();
    serve("rr3_single_i", 64'h120, 64'hA5);
    pulse_pair(64'h130, 64'h230);
    serve("rr4_d_first", 64'h230, 64'hB6);
    chk("rr4_d_first_dv", 64'(bus.D_DATA_VALID), 64'd1);
    serve("rr4_i_second", 64'h130, 64'hA7);
    chk("rr4_i_second_dv", 64'(bus.I_DATA_VALID), 64'd1);
    step();

    // Backpressure
    bus.M_ADDR_READY = 1'b0;
    bus.I_ADDR_VALID = 1'b1; bus.I_ADDR = 64'h400;
    step(); clr();
    hs0 = hs_cnt;
    wait_mv("bp_wait");
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_valid", 64'(bus.M_ADDR_VALID), 64'd1);
      chk("bp_hold_addr", bus.M_ADDR, 64'h400);
      step();
    end
    chk("bp_5th_valid", 64'(bus.M_ADDR_VALID), 64'd1);
    bus.M_ADDR_READY = 1'b1;
    step();
    chk("bp_after_valid", 64'(bus.M_ADDR_VALID), 64'd0);
    chk("bp_one_handshake", 64'(hs_cnt - hs0), 64'd1);
    bus.M_DATA_VALID = 1'b1; bus.M_DATA = 64'h4444;
    step(); clr();
    chk("bp_i_dv", 64'(bus.I_DATA_VALID), 64'd1);
    step(); step();
    chk("bp_still_one", 64'(hs_cnt - hs0), 64'd1);

    // Kill in flight
    bus.D_ADDR_VALID = 1'b1; bus.D_ADDR = 64'h500;
    step(); clr();
    wait_mv("kill_wait");
    chk("kill_addr", bus.M_ADDR, 64'h500);
    step();
    bus.D_KILL = 1'b1;
    step(); clr();
    bus.M_DATA_VALID = 1'b1; bus.M_DATA = 64'h5555;
    step(); clr();
    chk("kill_no_d_dv", 64'(bus.D_DATA_VALID), 64'd0);
    chk("kill_no_i_dv", 64'(bus.I_DATA_VALID), 64'd0);
    chk("kill_busy", 64'(bus.BUSY), 64'd0);
    bus.D_ADDR_VALID = 1'b1; bus.D_ADDR = 64'h300;
    step(); clr();
    serve("kill_next", 64'h300, 64'h3333);
    chk("kill_next_d_dv", 64'(bus.D_DATA_VALID), 64'd1);
    chk("kill_next_d_data", bus.D_DATA, 64'h3333);
    step();

    // Overflow and kill priority
    bus.D_ADDR_VALID = 1'b1; bus.D_ADDR = 64'h600;
    step();
    bus.D_ADDR = 64'h610;
    step(); clr();
    chk("ovf_flag", 64'(bus.OVERFLOW), 64'h2);
    chk("ovf_addr_kept", bus.M_ADDR, 64'h600);
    step();
    bus.M_DATA_VALID = 1'b1; bus.M_DATA = 64'h6666;
    step(); clr();
    chk("ovf_d_dv", 64'(bus.D_DATA_VALID), 64'd1);
    hs0 = hs_cnt;
    bus.I_ADDR_VALID = 1'b1; bus.I_ADDR = 64'h700; bus.I_KILL = 1'b1;
    step(); clr();
    step(); step(); step();
    chk("killpri_valid", 64'(bus.M_ADDR_VALID), 64'd0);
    chk("killpri_busy", 64'(bus.BUSY), 64'd0);
    chk("killpri_no_read", 64'(hs_cnt - hs0), 64'd0);
    chk("killpri_ovf", 64'(bus.OVERFLOW), 64'h2);

    // Async reset during ISSUE
    bus.M_ADDR_READY = 1'b0;
    bus.I_ADDR_VALID = 1'b1; bus.I_ADDR = 64'h800;
    step(); clr();
    wait_mv("arst_wait");
    chk("arst_pre_valid", 64'(bus.M_ADDR_VALID), 64'd1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.M_ADDR_VALID), 64'd0);
    chk("arst_busy", 64'(bus.BUSY), 64'd0);
    chk("arst_ovf", 64'(bus.OVERFLOW), 64'd0);
    step();
    RSTN = 1'b1;
    bus.M_ADDR_READY = 1'b1;
    step();
    bus.M_DATA_VALID = 1'b1; bus.M_DATA = 64'hDEAD;
    step(); clr();
    chk("arst_stray_i_dv", 64'(bus.I_DATA_VALID), 64'd0);
    chk("arst_stray_d_dv", 64'(bus.D_DATA_VALID), 64'd0);
    step();
    chk("arst_stray_busy", 64'(bus.BUSY), 64'd0);
    chk("arst_i_data", bus.I_DATA, 64'd0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
